te_packet_serializer: RTL
=========================

# te_packet_serializer

Downstream stage of the trace encoder: accepts complete trace packets (type, byte length, payload) from the packet emitter and buffers them in a small packet FIFO. It frames each packet with a one-byte header and streams it out byte by byte over a valid/ready interface toward the trace sink (funnel or off-chip port). It counts packets dropped when the FIFO is full, so the encoder can raise a packets-lost condition.

## Interface
- PTYPE_W, 2, packet type width
- PAYLOAD_BYTES, 16, maximum payload bytes per packet (payload width = 8*PAYLOAD_BYTES)
- LEN_W, 5, packet length field width (must hold PAYLOAD_BYTES)
- FIFO_DEPTH, 4, packet FIFO entries (power of two, ≥2)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- packet_valid_i  in  1  packet present this cycle
- packet_type_i  in  PTYPE_W  packet type
- packet_length_i  in  LEN_W  payload length in bytes
- packet_payload_i  in  8*PAYLOAD_BYTES  payload, byte 0 = bits [7:0]
- packet_ready_o  out  1  FIFO not full (push will be accepted)
- flush_i  in  1  discard all queued packets not yet started
- data_o  out  8  output byte
- valid_o  out  1  data_o valid
- ready_i  in  1  sink accepts byte
- last_o  out  1  data_o is final byte of packet
- overflow_o  out  1  sticky: at least one packet dropped
- drop_cnt_o  out  8  dropped packet count, saturating at 255
- clear_drop_i  in  1  clears overflow_o and drop_cnt_o

## Operation
- Push: packet_valid_i && packet_ready_o stores {type, length, payload}. packet_ready_o = (count != FIFO_DEPTH), based on registered count. A push while full is dropped even if a pop occurs the same cycle.
- Drop: packet_valid_i && !packet_ready_o sets overflow_o and increments drop_cnt_o (saturating at 255). clear_drop_i has priority over a simultaneous drop; the counter and flag read 0 next cycle.
- Length rule: length is clamped to PAYLOAD_BYTES at push. Length 0 is legal: the header is sent with last_o=1.
- Header byte: {type[1:0], 1'b0, clamped length[4:0]}. Type bits above bit 1 are ignored.
- FSM states:
  - IDLE: valid_o=0. If FIFO is non-empty, go to HDR.
  - HDR: data_o = header. On handshake: if length=0, pop and go to IDLE/HDR; else set byte index=0 and go to PAY.
  - PAY: data_o = payload byte[index]. On handshake: if index = length-1, assert pop; else index+1.
- Pop and next header: the head entry is popped on the handshake of its last byte. If the FIFO still holds another packet, the FSM goes straight to HDR with no bubble cycle; otherwise it goes to IDLE.
- Simultaneous push and pop: count is unchanged; both actions take effect.
- Flush: flush_i removes every entry except the one currently being serialized (state HDR/PAY). That entry completes normally. Flush in IDLE empties the FIFO. Push in the same cycle as flush is discarded and does not count as a drop.

## Timing
- Reset values: valid_o=0, data_o=0, last_o=0, overflow_o=0, drop_cnt_o=0, FIFO empty, packet_ready_o=1, FSM=IDLE, index=0.
- Latency: a packet pushed into an empty FIFO in cycle N shows its header valid_o=1 in cycle N+1. Payload byte k appears no earlier than cycle N+2+k.
- Throughput: one byte per cycle while ready_i=1. A packet of L bytes occupies the port for L+1 cycles.
- Output stability: while valid_o && !ready_i, data_o, last_o and valid_o hold stable. valid_o does not depend combinationally on ready_i.
- All outputs are driven from registers, except packet_ready_o, which is decoded from the registered count.
- Reset mid-packet: outputs return to reset values asynchronously. The partial packet and all queued entries are lost. Reset drops are not counted.

## Test plan
- Single packet: push type=2, length=3, payload bytes 0x11,0x22,0x33, ready_i=1 → output bytes 0x83, 0x11, 0x22, 0x33 on consecutive cycles; last_o only on 0x33; header appears one cycle after the push.
- Back-pressure: same packet with ready_i toggling 1,0,0,1… → no byte lost or duplicated; data_o stable during stalls.
- Overflow: hold ready_i=0 and push 6 packets → first 4 accepted; packet_ready_o=0 after the 4th; overflow_o=1; drop_cnt_o=2; clear_drop_i returns both to 0.
- Back-to-back: two queued packets of lengths 0 and 2 → header(len0, last_o=1), header, b0, b1(last_o=1) with no bubble cycles.
- Clamp: push length=31 → header length field=16; 16 payload bytes follow.
- Flush: flush_i asserted while packet A is in PAY with B and C queued → A completes; B and C are never emitted; packet_ready_o=1 next cycle.

Source files
------------

// File: rtl/te_packet_serializer.sv
// Trace packet serializer: buffers complete packets in a small FIFO and streams
// each one out as a header byte followed by its payload bytes over valid/ready.
module te_packet_serializer #(
  parameter int PTYPE_W       = 2,
  parameter int PAYLOAD_BYTES = 16,
  parameter int LEN_W         = 5,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       packet_valid_i,
  input  logic [PTYPE_W-1:0]         packet_type_i,
  input  logic [LEN_W-1:0]           packet_length_i,
  input  logic [8*PAYLOAD_BYTES-1:0] packet_payload_i,
  output logic                       packet_ready_o,
  input  logic                       flush_i,
  output logic [7:0]                 data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o,
  input  logic                       clear_drop_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAY_W = 8 * PAYLOAD_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(PAYLOAD_BYTES)) begin
      return LEN_W'(PAYLOAD_BYTES);
    end else begin
      return len;
    end
  endfunction

  function automatic logic [7:0] header_byte(input logic [PTYPE_W-1:0] ptype,
                                             input logic [LEN_W-1:0]   len);
    return {ptype[1:0], 1'b0, len[4:0]};
  endfunction

  function automatic logic [7:0] payload_byte(input logic [PAY_W-1:0] payload,
                                              input logic [LEN_W-1:0] idx);
    logic [PAY_W-1:0] shifted;
    shifted = payload >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

  logic [PTYPE_W-1:0] mem_type    [FIFO_DEPTH];
  logic [LEN_W-1:0]   mem_len     [FIFO_DEPTH];
  logic [PAY_W-1:0]   mem_payload [FIFO_DEPTH];

  state_e             state_r;
  logic [LEN_W-1:0]   idx_r;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [7:0]         data_r;
  logic               valid_r;
  logic               last_r;
  logic               overflow_r;
  logic [7:0]         drop_cnt_r;

  logic               push_s;
  logic               drop_s;
  logic               hs_s;
  logic               pop_s;
  logic               have_next_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic [LEN_W-1:0]   head_len_s;
  logic [LEN_W-1:0]   in_len_s;
  logic [LEN_W-1:0]   idx_inc_s;

  assign packet_ready_o = (count_r != CNT_W'(FIFO_DEPTH));
  assign push_s      = packet_valid_i && packet_ready_o && !flush_i;
  assign drop_s      = packet_valid_i && !packet_ready_o && !flush_i;
  assign hs_s        = valid_r && ready_i;
  assign next_ptr_s  = rd_ptr_r + PTR_W'(1);
  assign head_len_s  = mem_len[rd_ptr_r];
  assign in_len_s    = clamp_len(packet_length_i);
  assign idx_inc_s   = idx_r + LEN_W'(1);
  // A flush discards everything behind the packet being popped, so it never chains.
  assign have_next_s = !flush_i && (count_r > CNT_W'(1));

  assign data_o     = data_r;
  assign valid_o    = valid_r;
  assign last_o     = last_r;
  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

  // Head entry leaves the FIFO on the handshake of its final byte.
  always_comb begin
    pop_s = 1'b0;
    if (hs_s && (state_r == HDR) && (head_len_s == LEN_W'(0))) begin
      pop_s = 1'b1;
    end else if (hs_s && (state_r == PAY) && (idx_r == head_len_s - LEN_W'(1))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Packet storage write port.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_type[wr_ptr_r]    <= packet_type_i;
      mem_len[wr_ptr_r]     <= in_len_s;
      mem_payload[wr_ptr_r] <= packet_payload_i;
    end
  end

  // FIFO pointers and occupancy; flush keeps only the entry in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r  <= CNT_W'(0);
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
    end else if (flush_i) begin
      if ((state_r == IDLE) || pop_s) begin
        count_r  <= CNT_W'(0);
        rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
        wr_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
      end else begin
        count_r  <= CNT_W'(1);
        wr_ptr_r <= next_ptr_s;
      end
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr_s;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer FSM with registered byte, valid and last outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      idx_r   <= LEN_W'(0);
      data_r  <= 8'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (pop_s) begin
      idx_r <= LEN_W'(0);
      if (have_next_s) begin
        state_r <= HDR;
        data_r  <= header_byte(mem_type[next_ptr_s], mem_len[next_ptr_s]);
        valid_r <= 1'b1;
        last_r  <= (mem_len[next_ptr_s] == LEN_W'(0));
      end else begin
        state_r <= IDLE;
        data_r  <= 8'd0;
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (!flush_i && (count_r != CNT_W'(0))) begin
            state_r <= HDR;
            data_r  <= header_byte(mem_type[rd_ptr_r], head_len_s);
            valid_r <= 1'b1;
            last_r  <= (head_len_s == LEN_W'(0));
          end else if (push_s) begin
            // Bypass the empty FIFO so the header appears the cycle after the push.
            state_r <= HDR;
            data_r  <= header_byte(packet_type_i, in_len_s);
            valid_r <= 1'b1;
            last_r  <= (in_len_s == LEN_W'(0));
          end
        end
        HDR: begin
          if (hs_s) begin
            state_r <= PAY;
            idx_r   <= LEN_W'(0);
            data_r  <= payload_byte(mem_payload[rd_ptr_r], LEN_W'(0));
            last_r  <= (head_len_s == LEN_W'(1));
          end
        end
        PAY: begin
          if (hs_s) begin
            idx_r  <= idx_inc_s;
            data_r <= payload_byte(mem_payload[rd_ptr_r], idx_inc_s);
            last_r <= (idx_inc_s == head_len_s - LEN_W'(1));
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= LEN_W'(0);
          data_r  <= 8'd0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Drop accounting; clear wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (clear_drop_i) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != 8'd255) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

endmodule
